// File: rtl/mult_io_pkg.sv
// Shared definitions for the multiplier input conditioner.
//   db_state_e          : key debounce FSM state encoding
//   DEBOUNCE_CYCLES_DEF : default number of stable cycles that accept a level change
//   OPERAND_W           : width of the switch operand
package mult_io_pkg;

  typedef enum logic [1:0] {
    DB_RELEASED     = 2'd0,
    DB_PRESS_WAIT   = 2'd1,
    DB_HELD         = 2'd2,
    DB_RELEASE_WAIT = 2'd3
  } db_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int OPERAND_W           = 8;

endpackage

// File: rtl/key_debounce.sv
// Synchronizer, debounce FSM and press-pulse generator for one active-low key.
// Build option: MULT_INPUT_DEBOUNCE_EN selects the counted debounce; without it
// a level is accepted after a single stable synchronized cycle and no counter exists.
// Ports:
//   clk_i       : clock
//   rst_i       : synchronous active-high reset
//   key_n_i     : raw asynchronous key, active-low
//   press_set_o : combinational strobe, high on the edge the FSM enters HELD from PRESS_WAIT
//   press_o     : registered one-cycle press pulse (high in the cycle after that edge)
module key_debounce
  import mult_io_pkg::*;
`ifdef MULT_INPUT_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
)
`endif
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic press_set_o,
  output logic press_o
);

  logic      key_s1_q;
  logic      key_s2_q;
  logic      key;
  logic      press_q;
  logic      settled;
  db_state_e state_q;
  db_state_e state_d;

  // Synchronizer flops reset to the released (high) level so a key held through
  // reset is seen as a fresh press once reset drops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
      state_q  <= DB_RELEASED;
      press_q  <= 1'b0;
    end else begin
      key_s1_q <= key_n_i;
      key_s2_q <= key_s1_q;
      state_q  <= state_d;
      press_q  <= press_set_o;
    end
  end

  assign key = ~key_s2_q;

`ifdef MULT_INPUT_DEBOUNCE_EN
  localparam logic [15:0] LAST_CNT = 16'(DEBOUNCE_CYCLES - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign settled = (cnt_q == LAST_CNT);

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Count only while staying in a wait state; any state change restarts at 0.
  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) &&
        ((state_q == DB_PRESS_WAIT) || (state_q == DB_RELEASE_WAIT)))
      cnt_d = sat_inc(cnt_q);
  end
`else
  assign settled = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    press_set_o = 1'b0;
    unique case (state_q)
      DB_RELEASED: begin
        if (key) state_d = DB_PRESS_WAIT;
      end
      DB_PRESS_WAIT: begin
        if (!key) begin
          state_d = DB_RELEASED;
        end else if (settled) begin
          state_d     = DB_HELD;
          press_set_o = 1'b1;
        end
      end
      DB_HELD: begin
        if (!key) state_d = DB_RELEASE_WAIT;
      end
      DB_RELEASE_WAIT: begin
        // Bounce back to HELD is silent: only a fresh press from RELEASED pulses.
        if (key)          state_d = DB_HELD;
        else if (settled) state_d = DB_RELEASED;
      end
      default: state_d = DB_RELEASED;
    endcase
  end

  assign press_o = press_q;

endmodule

// File: rtl/mult_input_conditioner.sv
// Front-end for the multiplier: debounces the Run and Reset/Load/Clear keys,
// synchronizes the operand switches, captures the operand on an RLC press and
// holds a one-deep Run request until the controller is Ready.
// Build option: MULT_INPUT_DEBOUNCE_EN enables the counted debounce
// (DEBOUNCE_CYCLES); without it the parameter has no effect and keys settle
// after one stable synchronized cycle.
// Ports:
//   Clk                : clock
//   Reset              : synchronous active-high reset
//   Run_n              : raw Run key, active-low
//   Reset_Load_Clear_n : raw RLC key, active-low
//   SW[7:0]            : raw operand switches
//   Ready              : controller can accept a run
//   Run                : one-cycle run request
//   Reset_Load_Clear   : one-cycle RLC pulse
//   Load_Data[7:0]     : switch value captured at the RLC press
//   Run_Pending        : debounced run press waiting for Ready
module mult_input_conditioner
  import mult_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Run_n,
  input  logic                 Reset_Load_Clear_n,
  input  logic [OPERAND_W-1:0] SW,
  input  logic                 Ready,
  output logic                 Run,
  output logic                 Reset_Load_Clear,
  output logic [OPERAND_W-1:0] Load_Data,
  output logic                 Run_Pending
);

  logic                 run_set;
  logic                 run_press_q;
  logic                 rlc_set;
  logic                 rlc_press_q;
  logic [OPERAND_W-1:0] sw_s1_q;
  logic [OPERAND_W-1:0] sw_s2_q;
  logic [OPERAND_W-1:0] load_q;
  logic [OPERAND_W-1:0] load_d;
  logic                 pend_q;
  logic                 pend_d;
  logic                 run_q;
  logic                 run_d;

`ifdef MULT_INPUT_DEBOUNCE_EN
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_key (
    .clk_i(Clk), .rst_i(Reset), .key_n_i(Run_n),
    .press_set_o(run_set), .press_o(run_press_q)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rlc_key (
    .clk_i(Clk), .rst_i(Reset), .key_n_i(Reset_Load_Clear_n),
    .press_set_o(rlc_set), .press_o(rlc_press_q)
  );
`else
  key_debounce u_run_key (
    .clk_i(Clk), .rst_i(Reset), .key_n_i(Run_n),
    .press_set_o(run_set), .press_o(run_press_q)
  );
  key_debounce u_rlc_key (
    .clk_i(Clk), .rst_i(Reset), .key_n_i(Reset_Load_Clear_n),
    .press_set_o(rlc_set), .press_o(rlc_press_q)
  );

  logic [15:0] unused_debounce_cycles;
  assign unused_debounce_cycles = 16'(DEBOUNCE_CYCLES);
`endif

  // The run request is driven from the set strobe so Run and Run_Pending can
  // rise in the same cycle as the press pulse; the registered pulse is spare.
  logic unused_run_press;
  assign unused_run_press = run_press_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      load_q  <= '0;
      pend_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      sw_s1_q <= SW;
      sw_s2_q <= sw_s1_q;
      load_q  <= load_d;
      pend_q  <= pend_d;
      run_q   <= run_d;
    end
  end

  // RLC has top priority: it clears the pending run and blocks Run on the same
  // edge. A run that just fired clears the request, absorbing any press that
  // lands while it was still pending.
  always_comb begin
    load_d = load_q;
    if (rlc_set) load_d = sw_s2_q;

    pend_d = pend_q;
    if (rlc_set)      pend_d = 1'b0;
    else if (run_q)   pend_d = 1'b0;
    else if (run_set) pend_d = 1'b1;

    run_d = (pend_q | run_set) & Ready & ~run_q & ~rlc_set;
  end

  assign Run              = run_q;
  assign Reset_Load_Clear = rlc_press_q;
  assign Load_Data        = load_q;
  assign Run_Pending      = pend_q;

endmodule

// File: tb/tb_mult_input_conditioner.sv
module tb_mult_input_conditioner;

  localparam int N = 4;
`ifdef MULT_INPUT_DEBOUNCE_EN
  localparam int EFF = N;
`else
  localparam int EFF = 1;
`endif
  // Press pulse lands EFF+2 edges after the first edge that samples the key low.
  localparam int P = EFF + 2;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Run_n;
  logic       Reset_Load_Clear_n;
  logic [7:0] SW;
  logic       Ready;
  logic       Run;
  logic       Reset_Load_Clear;
  logic [7:0] Load_Data;
  logic       Run_Pending;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  mult_input_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Run_n(Run_n),
    .Reset_Load_Clear_n(Reset_Load_Clear_n),
    .SW(SW),
    .Ready(Ready),
    .Run(Run),
    .Reset_Load_Clear(Reset_Load_Clear),
    .Load_Data(Load_Data),
    .Run_Pending(Run_Pending)
  );

  task automatic check(input string tag, input int cyc, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Run_n = 1'b1;
    Reset_Load_Clear_n = 1'b1;
    Ready = 1'b0;
    SW = 8'h00;
    step();
    step();
    Reset = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_b;
    int r_e;
    int q_f;

    // Reset state with both keys held and switches set: outputs stay cleared.
    Reset = 1'b1;
    Run_n = 1'b0;
    Reset_Load_Clear_n = 1'b0;
    SW = 8'hFF;
    Ready = 1'b1;
    step();
    step();
    step();
    check("rst_run", 0, Run, 1'b0);
    check("rst_rlc", 0, Reset_Load_Clear, 1'b0);
    check("rst_pend", 0, Run_Pending, 1'b0);
    check("rst_load", 0, Load_Data, 8'h00);

    // Keys held through reset: both press on the same edge, RLC wins.
    Reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      check("hold_rlc", k, Reset_Load_Clear, (k == P));
      check("hold_run", k, Run, 1'b0);
      check("hold_pend", k, Run_Pending, 1'b0);
      check("hold_load", k, Load_Data, (k >= P) ? 8'hFF : 8'h00);
    end

    // Clean Run press held 20 cycles with Ready high, then released.
    do_reset();
    Ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      Run_n = (k < 20) ? 1'b0 : 1'b1;
      step();
      check("a_run", k, Run, (k == P));
      check("a_pend", k, Run_Pending, (k == P));
      check("a_rlc", k, Reset_Load_Clear, 1'b0);
    end

    // Bounce 3 low / 2 high / 3 low, then a clean press from cycle 16.
    exp_b = '0;
    exp_b[16 + P] = 1'b1;
`ifndef MULT_INPUT_DEBOUNCE_EN
    exp_b[3] = 1'b1;
    exp_b[8] = 1'b1;
`endif
    do_reset();
    Ready = 1'b1;
    for (int k = 0; k < 28; k++) begin
      Run_n = ((k <= 2) || (k >= 5 && k <= 7) || (k >= 16)) ? 1'b0 : 1'b1;
      step();
      check("b_run", k, Run, exp_b[k]);
      check("b_pend", k, Run_Pending, exp_b[k]);
    end

    // Press with Ready low; Ready rises at cycle 15.
    do_reset();
    for (int k = 0; k < 25; k++) begin
      Run_n = (k < 20) ? 1'b0 : 1'b1;
      Ready = (k >= 15) ? 1'b1 : 1'b0;
      step();
      check("c_run", k, Run, (k == 15));
      check("c_pend", k, Run_Pending, (k >= P && k <= 15));
    end

    // RLC press captures 0xA5; later switch change without a press is ignored.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      SW = (k < 10) ? 8'hA5 : 8'h3C;
      Reset_Load_Clear_n = (k < 10) ? 1'b0 : 1'b1;
      step();
      check("d_rlc", k, Reset_Load_Clear, (k == P));
      check("d_load", k, Load_Data, (k >= P) ? 8'hA5 : 8'h00);
      check("d_run", k, Run, 1'b0);
    end

    // Pending run, then RLC pulse in the same cycle Ready rises.
    r_e = 4 + P;
    do_reset();
    for (int k = 0; k < r_e + 4; k++) begin
      Run_n = 1'b0;
      Reset_Load_Clear_n = (k >= 4) ? 1'b0 : 1'b1;
      Ready = (k >= r_e) ? 1'b1 : 1'b0;
      step();
      check("e_run", k, Run, 1'b0);
      check("e_rlc", k, Reset_Load_Clear, (k == r_e));
      if (k != r_e) check("e_pend", k, Run_Pending, (k >= P && k < r_e));
    end

    // Reset at cycles 3-4 of a held press: single pulse after reset drops.
    q_f = 5 + P;
    do_reset();
    Ready = 1'b1;
    for (int k = 0; k < q_f + 6; k++) begin
      Run_n = 1'b0;
      Reset = (k == 3 || k == 4) ? 1'b1 : 1'b0;
      step();
      check("f_run", k, Run, (k == q_f));
      check("f_pend", k, Run_Pending, (k == q_f));
    end
    Reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
